// File: rtl/audio_out_serializer.sv
// Stereo DAC serializer: valid/ready pair FIFO feeding an MSB-first shift register
// framed by the lr-clock strobes. Define I2S_ONE_BIT_DELAY_EN for I2S one-bit-delay framing.
module audio_out_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          bit_clk_rising_edge,
    input  logic                          bit_clk_falling_edge,
    input  logic                          left_right_clk_rising_edge,
    input  logic                          left_right_clk_falling_edge,
    input  logic [DATA_WIDTH-1:0]         left_data,
    input  logic [DATA_WIDTH-1:0]         right_data,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          clear_fifo,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_space,
    output logic                          serial_data_out,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef I2S_ONE_BIT_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif
    // The shift register carries the delay bit on top, so a load zero-extends the sample.
    localparam int SW = DATA_WIDTH + DLY;
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] BIT_MAX = CW'(SW);
    localparam logic [CW-1:0] BIT_ONE = CW'(1);
    localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  fifo_empty, push, pop, lr_rise, lr_fall;

    state_t                state_q, state_d;
    logic [SW-1:0]         shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  underflow_d;

    logic unused_bit_clk_rise;
    assign unused_bit_clk_rise = bit_clk_rising_edge;

    assign fifo_empty   = (count == '0);
    assign sample_ready = (count != DEPTH);
    assign fifo_space   = DEPTH - count;
    assign lr_rise      = left_right_clk_rising_edge;
    assign lr_fall      = left_right_clk_falling_edge & ~left_right_clk_rising_edge;
    assign push         = sample_valid & sample_ready & ~clear_fifo;
    assign pop          = lr_rise & ~fifo_empty & ~clear_fifo;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= left_data;
            mem_r[wr_ptr] <= right_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_fifo) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        bit_cnt_d   = bit_cnt_q;
        underflow_d = 1'b0;
        if (lr_rise) begin
            state_d   = LEFT;
            bit_cnt_d = '0;
            if (pop) begin
                shift_d = SW'(mem_l[rd_ptr]);
                hold_d  = mem_r[rd_ptr];
            end else begin
                // Empty FIFO (or a flush in the same cycle) sends a silent slot.
                shift_d     = '0;
                hold_d      = '0;
                underflow_d = fifo_empty;
            end
        end else if (lr_fall) begin
            bit_cnt_d = '0;
            if (state_q == IDLE) begin
                shift_d = '0;
            end else begin
                shift_d = SW'(hold_q);
                state_d = RIGHT;
            end
        end else if (bit_clk_falling_edge && state_q != IDLE && bit_cnt_q != BIT_MAX) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
    end

    // Output is registered from the next shift value so a load or shift shows one clk later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            shift_q         <= '0;
            hold_q          <= '0;
            bit_cnt_q       <= '0;
            serial_data_out <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            hold_q          <= hold_d;
            bit_cnt_q       <= bit_cnt_d;
            serial_data_out <= shift_d[SW-1];
            underflow       <= underflow_d;
        end
    end

endmodule

// File: doc/audio_out_serializer.md
# audio_out_serializer

Transmit-side counterpart of the audio ADC bit-counting path: accepts stereo sample pairs through a valid/ready handshake, buffers them in a small FIFO, and shifts them out MSB-first on the codec DAC data line. It uses the same pre-decoded bit-clock and left/right-clock edge strobes as the rest of the audio core, all synchronous to the single system clock. It sits between the audio DMA/register front end and the codec pin interface.

## Interface

- DATA_WIDTH, 24, bits per channel sample; legal range 1..32.
- FIFO_DEPTH, 4, stereo pairs buffered; power of two, 2..64.

- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bit_clk_rising_edge  in  1  one-cycle strobe; unused except by the test monitor and reserved.
- bit_clk_falling_edge  in  1  one-cycle strobe; advances the serial bit.
- left_right_clk_rising_edge  in  1  one-cycle strobe; starts the left channel slot.
- left_right_clk_falling_edge  in  1  one-cycle strobe; starts the right channel slot.
- left_data  in  DATA_WIDTH  left sample, two's complement.
- right_data  in  DATA_WIDTH  right sample.
- sample_valid  in  1  left_data/right_data hold a pair.
- sample_ready  out  1  FIFO can accept a pair (not full).
- clear_fifo  in  1  synchronous FIFO flush.
- fifo_space  out  clog2(FIFO_DEPTH)+1  free pair slots.
- serial_data_out  out  1  registered DAC data bit.
- underflow  out  1  one-cycle pulse: slot started with FIFO empty.

## Operation

- Reset values: sample_ready=1, fifo_space=FIFO_DEPTH, serial_data_out=0, underflow=0; FIFO empty; shift register, holding register and bit counter 0; state IDLE.
- Write: pair pushed when sample_valid & sample_ready. sample_ready = (count != FIFO_DEPTH), derived from registered count.
- clear_fifo: count and pointers to 0 next cycle; has priority over write and pop in the same cycle; shift and holding registers are not touched.
- States: IDLE, LEFT, RIGHT. IDLE -> LEFT on lr rising edge; LEFT -> RIGHT on lr falling edge; RIGHT -> LEFT on lr rising edge. Reset returns to IDLE from any state, mid-frame included.
- On lr rising edge: if FIFO non-empty, pop one pair; left goes to the shift register, right to the holding register. If empty: shift and holding registers load 0, underflow pulses for one cycle, and count stays 0.
- On lr falling edge: holding register loads into the shift register. In IDLE, the falling edge loads 0 and the state stays IDLE.
- Shifting: on bit_clk_falling_edge in LEFT/RIGHT, shift left by one and fill with 0; bit counter increments, saturating at DATA_WIDTH. After DATA_WIDTH shifts the output is 0 until the next lr edge (padding).
- Simultaneous push and pop with FIFO non-full: both occur and count is unchanged.
- lr edge and bit_clk_falling_edge in the same cycle: the load wins and no shift occurs.
- Both lr edges in the same cycle: treated as a rising edge only.

## Timing

- serial_data_out is registered from the shift-register MSB (or the delay bit). It shows the new slot's first bit one clk after the lr edge strobe.
- Each later bit appears one clk after the bit_clk_falling_edge that advances it.
- fifo_space and sample_ready update one clk after a push, pop or clear.
- underflow is asserted in the clk following the empty-slot lr rising edge, for exactly one cycle.
- Pop-to-output latency: one clk.

## Configuration

- I2S_ONE_BIT_DELAY_EN defined: I2S framing. Each slot begins with one 0 bit; the MSB appears after the first bit_clk_falling_edge following the lr edge. The bit counter counts DATA_WIDTH+1 shifts before padding.
- Not defined: left-justified framing. The MSB appears one clk after the lr edge.

## Test plan

- Reset, then push L=0xA5A5A5, R=0x5A5A5A, run 48 bit clocks per half-frame -> serial stream is the 24 bits MSB-first followed by 24 zeros per slot; fifo_space back to 4 after the pop.
- Push 4 pairs with no lr edges -> sample_ready=0 and fifo_space=0; a 5th sample_valid is not accepted; the next lr rising edge restores fifo_space=1.
- No pushes, lr rising edge -> underflow high for exactly one cycle and serial_data_out=0 for the whole frame.
- Push and lr rising pop in the same cycle with 2 entries -> fifo_space stays 2.
- clear_fifo with 3 entries during an active left slot -> fifo_space=4 next cycle; the current left sample finishes shifting unchanged.
- With I2S_ONE_BIT_DELAY_EN, send L=0x800001 -> first bit 0, second bit 1 (MSB), LSB at the 25th bit; reset_n asserted mid-slot -> serial_data_out=0 immediately and state IDLE.
